// File: rtl/traffic_light_monitor_if.sv
// Lamp observation and status bus for traffic_light_monitor.
// master: drives the lamps and clear_fault, reads the status (bench or controller side).
// slave : the monitor, which samples the lamps and drives the status outputs.
//   red_light/yellow_light/green_light : lamp levels under observation
//   clear_fault                        : one-cycle pulse, clears fault and fault_code
//   fault/fault_code/fault_count       : sticky flag, first code since clear, saturating total
//   phase/phase_done/last_phase/last_len: tracked phase and the most recently ended phase
//   cycles                             : legal YELLOW->RED transitions, wraps
interface traffic_light_monitor_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic             red_light;
  logic             yellow_light;
  logic             green_light;
  logic             clear_fault;
  logic             fault;
  logic [2:0]       fault_code;
  logic [7:0]       fault_count;
  logic [1:0]       phase;
  logic             phase_done;
  logic [1:0]       last_phase;
  logic [CNT_W-1:0] last_len;
  logic [15:0]      cycles;

  modport master (
    output red_light, yellow_light, green_light, clear_fault,
    input  fault, fault_code, fault_count, phase, phase_done,
    input  last_phase, last_len, cycles
  );

  modport slave (
    input  red_light, yellow_light, green_light, clear_fault,
    output fault, fault_code, fault_count, phase, phase_done,
    output last_phase, last_len, cycles
  );

endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker on traffic light lamps. Tracks RED -> GREEN -> YELLOW -> RED,
// flags non-one-hot patterns, illegal transitions and dwell-time violations,
// and reports per-phase lengths and completed-cycle counts.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   mon   : traffic_light_monitor_if.slave (lamps/clear_fault in, status out)
module traffic_light_monitor #(
  parameter int unsigned GREEN_MIN  = 3,
  parameter int unsigned GREEN_MAX  = 6,
  parameter int unsigned YELLOW_MIN = 2,
  parameter int unsigned YELLOW_MAX = 3,
  parameter int unsigned RED_MIN    = 3,
  parameter int unsigned RED_MAX    = 6,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  traffic_light_monitor_if.slave mon
);

  localparam int unsigned CODE_W = 3;
  localparam int unsigned FCNT_W = 8;
  localparam int unsigned CYC_W  = 16;

  localparam logic [CODE_W-1:0] F_NONE    = CODE_W'(0);
  localparam logic [CODE_W-1:0] F_ONEHOT  = CODE_W'(1);
  localparam logic [CODE_W-1:0] F_ILLEGAL = CODE_W'(2);
  localparam logic [CODE_W-1:0] F_SHORT   = CODE_W'(3);
  localparam logic [CODE_W-1:0] F_LONG    = CODE_W'(4);

  localparam logic [CNT_W-1:0]  DWELL_SAT = {CNT_W{1'b1}};
  localparam logic [FCNT_W-1:0] FCNT_SAT  = {FCNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RED    = 2'd1,
    ST_GREEN  = 2'd2,
    ST_YELLOW = 2'd3
  } state_t;

  // Minimum legal dwell of a phase
  function automatic logic [CNT_W-1:0] min_of(input state_t s);
    logic [CNT_W-1:0] v;
    v = '0;
    case (s)
      ST_RED:    v = CNT_W'(RED_MIN);
      ST_GREEN:  v = CNT_W'(GREEN_MIN);
      ST_YELLOW: v = CNT_W'(YELLOW_MIN);
      default:   v = '0;
    endcase
    return v;
  endfunction

  // Maximum legal dwell of a phase
  function automatic logic [CNT_W-1:0] max_of(input state_t s);
    logic [CNT_W-1:0] v;
    v = DWELL_SAT;
    case (s)
      ST_RED:    v = CNT_W'(RED_MAX);
      ST_GREEN:  v = CNT_W'(GREEN_MAX);
      ST_YELLOW: v = CNT_W'(YELLOW_MAX);
      default:   v = DWELL_SAT;
    endcase
    return v;
  endfunction

  // Legal successor of a phase
  function automatic state_t succ_of(input state_t s);
    state_t v;
    v = ST_IDLE;
    case (s)
      ST_RED:    v = ST_GREEN;
      ST_GREEN:  v = ST_YELLOW;
      ST_YELLOW: v = ST_RED;
      default:   v = ST_IDLE;
    endcase
    return v;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    dwell_q, dwell_d;
  logic                partial_q, partial_d;
  logic                long_q, long_d;
  logic                fault_q, fault_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                done_q, done_d;
  state_t              last_phase_q, last_phase_d;
  logic [CNT_W-1:0]    last_len_q, last_len_d;
  logic [CYC_W-1:0]    cycles_q, cycles_d;

  logic                onehot_c;
  state_t              obs_c;
  logic [CNT_W-1:0]    dwell_inc_c;
  logic [CODE_W-1:0]   det_c;

  // Lamp decode: exactly one lamp lit, and which phase it names
  always_comb begin
    onehot_c = (mon.red_light ^ mon.yellow_light ^ mon.green_light) &
               ~(mon.red_light & mon.yellow_light & mon.green_light);
    if (mon.red_light)        obs_c = ST_RED;
    else if (mon.green_light) obs_c = ST_GREEN;
    else                      obs_c = ST_YELLOW;
    dwell_inc_c = (dwell_q == DWELL_SAT) ? dwell_q : dwell_q + CNT_W'(1);
  end

  // Phase tracking, fault detection and status next-state
  always_comb begin
    state_d      = state_q;
    dwell_d      = dwell_q;
    partial_d    = partial_q;
    long_d       = long_q;
    fault_d      = fault_q;
    code_d       = code_q;
    fcnt_d       = fcnt_q;
    done_d       = 1'b0;
    last_phase_d = last_phase_q;
    last_len_d   = last_len_q;
    cycles_d     = cycles_q;
    det_c        = F_NONE;

    if (!onehot_c) begin
      det_c     = F_ONEHOT;
      state_d   = ST_IDLE;
      dwell_d   = '0;
      partial_d = 1'b0;
      long_d    = 1'b0;
    end else if (state_q == ST_IDLE) begin
      // Resync: the first phase seen is of unknown age, so skip its MIN check
      state_d   = obs_c;
      dwell_d   = CNT_W'(1);
      partial_d = 1'b1;
      long_d    = 1'b0;
    end else if (obs_c == state_q) begin
      dwell_d = dwell_inc_c;
      if (!long_q && (dwell_inc_c > max_of(state_q))) begin
        det_c  = F_LONG;
        long_d = 1'b1;
      end
    end else begin
      done_d       = 1'b1;
      last_phase_d = state_q;
      last_len_d   = dwell_q;
      // Illegal transition takes precedence over too-short in the same cycle
      if (obs_c != succ_of(state_q)) begin
        det_c = F_ILLEGAL;
      end else if (!partial_q && (dwell_q < min_of(state_q))) begin
        det_c = F_SHORT;
      end
      if ((state_q == ST_YELLOW) && (obs_c == ST_RED)) begin
        cycles_d = cycles_q + CYC_W'(1);
      end
      state_d   = obs_c;
      dwell_d   = CNT_W'(1);
      partial_d = 1'b0;
      long_d    = 1'b0;
    end

    // First fault since clear owns the code; a new fault beats a same-cycle clear
    if (det_c != F_NONE) begin
      fault_d = 1'b1;
      if (!fault_q || mon.clear_fault) begin
        code_d = det_c;
      end
      if (fcnt_q != FCNT_SAT) begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end else if (mon.clear_fault) begin
      fault_d = 1'b0;
      code_d  = F_NONE;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      dwell_q      <= '0;
      partial_q    <= 1'b0;
      long_q       <= 1'b0;
      fault_q      <= 1'b0;
      code_q       <= F_NONE;
      fcnt_q       <= '0;
      done_q       <= 1'b0;
      last_phase_q <= ST_IDLE;
      last_len_q   <= '0;
      cycles_q     <= '0;
    end else begin
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      partial_q    <= partial_d;
      long_q       <= long_d;
      fault_q      <= fault_d;
      code_q       <= code_d;
      fcnt_q       <= fcnt_d;
      done_q       <= done_d;
      last_phase_q <= last_phase_d;
      last_len_q   <= last_len_d;
      cycles_q     <= cycles_d;
    end
  end

  assign mon.fault       = fault_q;
  assign mon.fault_code  = code_q;
  assign mon.fault_count = fcnt_q;
  assign mon.phase       = state_q;
  assign mon.phase_done  = done_q;
  assign mon.last_phase  = last_phase_q;
  assign mon.last_len    = last_len_q;
  assign mon.cycles      = cycles_q;

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker on the lamp outputs of the traffic light controller. Samples `red_light`, `yellow_light` and `green_light` every clock and tracks the phase sequence RED → GREEN → YELLOW → RED. Flags invalid lamp patterns, illegal transitions and phase dwell times outside configured bounds. Reports per-phase lengths and completed-cycle counts for the verification bench and the on-chip status readout.

## Interface
- `GREEN_MIN`, 3: minimum legal GREEN dwell, in cycles
- `GREEN_MAX`, 6: maximum legal GREEN dwell, in cycles
- `YELLOW_MIN`, 2: minimum legal YELLOW dwell
- `YELLOW_MAX`, 3: maximum legal YELLOW dwell
- `RED_MIN`, 3: minimum legal RED dwell
- `RED_MAX`, 6: maximum legal RED dwell
- `CNT_W`, 8: dwell counter width; all MIN/MAX values are < 2^CNT_W−1
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `red_light` in 1: lamp under observation (same clock domain)
- `yellow_light` in 1: lamp under observation
- `green_light` in 1: lamp under observation
- `clear_fault` in 1: one-cycle pulse; clears `fault` and `fault_code`
- `fault` out 1: sticky fault flag
- `fault_code` out 3: code of the first fault since the last clear
- `fault_count` out 8: total faults detected; saturates at 255
- `phase` out 2: current tracked phase (0 IDLE, 1 RED, 2 GREEN, 3 YELLOW)
- `phase_done` out 1: one-cycle pulse when a phase ends on a valid transition
- `last_phase` out 2: phase that just ended
- `last_len` out CNT_W: dwell of that phase, in cycles
- `cycles` out 16: count of legal YELLOW→RED transitions; wraps modulo 2^16

## Operation
- Lamp pattern per cycle: exactly one lamp high → valid (R, G or Y). Anything else → invalid.
- States: IDLE, RED, GREEN, YELLOW. All outputs are registered.
- IDLE → matching state on the first valid pattern. No transition check. Sets `partial` = 1.
- From IDLE, dwell starts at 1 on entry. Dwell increments each cycle the same lamp persists and saturates at 2^CNT_W−1.
- Change to a different valid lamp ends the phase:
  - `phase_done` = 1, `last_phase` = old state, `last_len` = final dwell.
  - If the transition is not R→G, G→Y or Y→R: fault 2 (illegal transition).
  - If `partial` = 0 and dwell < MIN of the old phase: fault 3 (too short).
  - The new state is always entered, dwell = 1, `partial` = 0.
- When dwell reaches MAX+1 while the phase continues: fault 4 (too long). Fires once per phase, via a per-phase latch.
- Invalid pattern: fault 1 (not one-hot). State → IDLE, dwell = 0, no `phase_done`. Repeated invalid cycles raise fault 1 on every cycle.
- Fault codes: 0 none, 1 not one-hot, 2 illegal transition, 3 too short, 4 too long.
- Fault reporting rules:
  - `fault_code` latches only when `fault` is 0 (first fault wins).
  - `fault_count` increments by 1 per cycle in which any fault is detected.
  - If faults 2 and 3 occur in the same cycle, code 2 is reported and the count increments by 1.
- `clear_fault` together with a new fault in the same cycle: the new fault wins (`fault` = 1, new code).
- `clear_fault` does not affect `fault_count`, `cycles`, state or dwell.

## Timing
- Reset values: state IDLE, dwell 0, `partial` 0, all outputs 0.
- Reset is asynchronous on assertion and synchronous on deassertion. Assertion mid-phase forces IDLE immediately; all history is discarded.
- Latency: a lamp pattern sampled at edge N is reflected in `phase`, `fault`, `phase_done` and `cycles` after edge N.
- `phase_done` is high for exactly one cycle per valid transition.
- Back-to-back transitions on consecutive cycles are legal to observe. Each one is evaluated, and a dwell of 1 is checked against MIN.

## Test plan
- Legal run G3/Y2/R3 after sync (R, G, Y, R...) → no fault. `last_len` = 3, 2, 3 on the matching `phase_done` pulses. `cycles` +1 per Y→R.
- Reset mid-GREEN (dwell 4), release, then RED held 1 cycle and GREEN → no too-short fault (partial phase). `phase` = 0 during reset.
- GREEN held 2 cycles then YELLOW → `fault_code` = 3 and `last_len` = 2. A following RED held 7 cycles → fault 4 on the 7th RED cycle, `fault_code` stays 3, `fault_count` = 2.
- RED → YELLOW after 3 cycles → `fault_code` = 2, `fault_count` = 1, state YELLOW.
- All lamps low for 2 cycles → `fault_code` = 1, `fault_count` = 2, `phase` = 0. Next valid GREEN resyncs without fault 2.
- `clear_fault` pulsed in the same cycle as R&G both high → `fault` = 1, `fault_code` = 1. `clear_fault` pulsed alone → `fault` = 0, `fault_code` = 0, `fault_count` unchanged.
